instr_enc: RTL and testbench
============================

# instr_enc

RV32I instruction encoder: packs decoded fields (format, opcode, rd, func3, rs1, rs2, func7, immediate) into a 32-bit instruction word. It does the inverse of the core's field-extraction decoder. It sits between the test/boot program generator and the instruction-memory write port. It applies range and alignment checks on immediates and tags each word with a sequential word-aligned write address. It uses a valid/ready handshake on both sides with a one-entry output register.

## Interface
- ADDR_W, 32: width of the write address and the address counter.
- BASE_ADDR, 0: address counter value after reset; bits [1:0] are forced to 0.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle this cycle.
- fmt  in  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
- opcode  in  7  placed in bits [6:0].
- rd, rs1, rs2  in  5 each  register fields.
- func3  in  3  function field; func7  in  7  function field (R only).
- imm  in  32  signed byte immediate; for U this is the full value with bits [11:0] expected 0.
- addr_load  in  1  load the address counter from addr_val.
- addr_val  in  ADDR_W  new address; bits [1:0] are ignored and treated as 0.
- out_valid  out  1  out_instr/out_addr/out_err valid.
- out_ready  in  1  consumer accepts the output word.
- out_instr  out  32  encoded word.
- out_addr  out  ADDR_W  write address of out_instr.
- out_err  out  1  the bundle failed its checks; out_instr is the NOP.
- word_count  out  16  accepted bundles; saturates at 0xFFFF.
- err_count  out  16  accepted bundles with out_err=1; saturates at 0xFFFF.

## Operation
- Encoding (rs2 in [24:20], rs1 in [19:15], func3 in [14:12], rd in [11:7], opcode in [6:0]):
  - R: func7 in [31:25], plus rs2, rs1, func3, rd, opcode.
  - I: imm[11:0] in [31:20], plus rs1, func3, rd, opcode.
  - S: imm[11:5] in [31:25], imm[4:0] in [11:7], plus rs2, rs1, func3, opcode.
  - B: imm[12] in [31], imm[10:5] in [30:25], imm[4:1] in [11:8], imm[11] in [7], plus rs2, rs1, func3, opcode.
  - U: imm[31:12] in [31:12], plus rd, opcode.
  - J: imm[20] in [31], imm[10:1] in [30:21], imm[11] in [20], imm[19:12] in [19:12], plus rd, opcode.
- Unused fields for a format are ignored, e.g. func7 outside R and rd in S/B.
- Checks (any failure sets out_err=1 and replaces out_instr with the NOP 0x00000013):
  - I and S: imm within [-2048, 2047], meaning bits [31:11] are all equal.
  - B: imm within [-4096, 4094] and imm[0]=0.
  - J: imm within [-1048576, 1048574] and imm[0]=0.
  - U: imm[11:0]=0.
  - R: no check on imm.
  - fmt 6 or 7: always an error.
- Address counter (ADDR_W bits, modulo 2^ADDR_W, wraps silently):
  - An accept is in_valid && in_ready.
  - On accept, out_addr takes the counter value and the counter advances by 4.
  - addr_load with no accept: the counter loads {addr_val[ADDR_W-1:2], 2'b00}.
  - addr_load together with an accept: the accepted word gets the loaded value as out_addr, and the counter becomes loaded value + 4.
- Counters: word_count increments on every accept; err_count increments on accepts with an error. Both saturate at 0xFFFF.

## Timing
- in_ready = !out_valid || out_ready. This is combinational, so the block sustains full throughput with no bubbles.
- Latency: a bundle accepted at edge N appears with out_valid=1 from edge N until it is consumed (one register stage).
- out_valid rises on accept. It falls on an edge where out_valid && out_ready and no new accept occurs.
- If out_valid=1 and out_ready=0:
  - out_instr, out_addr and out_err stay stable.
  - in_ready=0, and the input fields are don't-care.
- Reset values: out_valid=0, out_instr=0x00000013, out_addr=0, out_err=0, counter=BASE_ADDR with low 2 bits cleared, word_count=0, err_count=0.
- Reset has priority over accept and addr_load. Reset mid-operation drops any held word without it being consumed.
- in_ready is 1 during the first cycle after reset.

## Test plan
- R add x3,x1,x2 (fmt0, op 0x33, f3 0, f7 0), out_ready=1 -> out_instr 0x002081B3, out_err 0, out_addr 0.
- I addi x1,x0,-1 (op 0x13, imm 0xFFFFFFFF), then S sw x2,8(x1) (op 0x23, f3 2) -> 0xFFF00093 at address 0, then 0x0020A423 at address 4.
- B beq x0,x0,-4 (op 0x63) -> 0xFE000EE3.
- J jal x1,8 (op 0x6F) -> 0x008000EF.
- B with imm=3, then I with imm=2048 -> both produce out_instr 0x00000013 with out_err 1; err_count 2.
- addr_load with addr_val 0x103, then three bundles with out_ready held 0 for 3 cycles on the second:
  - out_addr sequence is 0x100, 0x104, 0x108.
  - The second word stays stable while held, and in_ready is 0 while held.
  - Assert rst during the hold: out_valid=0 next cycle, and the counter returns to BASE_ADDR.

Source files
------------

// File: rtl/instr_enc.sv
// instr_enc: packs RV32I decoded fields into instruction words, checks immediates,
// tags each word with a sequential word address and holds it in a one-entry output register.
module instr_enc #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        func3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        func7,
    input  logic [31:0]       imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [15:0]       word_count,
    output logic [15:0]       err_count
);
    localparam logic [31:0]       NOP  = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] BASE = {BASE_ADDR[ADDR_W-1:2], 2'b00};

    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cur;
    logic [31:0]       enc;
    logic              ok;
    logic              acc;
    logic              fit_i;
    logic              fit_b;
    logic              fit_j;

    assign in_ready = !out_valid || out_ready;
    assign acc      = in_valid && in_ready;
    assign cur      = addr_load ? {addr_val[ADDR_W-1:2], 2'b00} : cnt;

    // A signed immediate fits in N bits when every bit from N-1 upward matches the sign.
    assign fit_i = &imm[31:11] | ~|imm[31:11];
    assign fit_b = &imm[31:12] | ~|imm[31:12];
    assign fit_j = &imm[31:20] | ~|imm[31:20];

    always_comb begin
        enc = NOP;
        ok  = 1'b0;
        case (fmt)
            3'd0: begin enc = {func7, rs2, rs1, func3, rd, opcode}; ok = 1'b1; end
            3'd1: begin enc = {imm[11:0], rs1, func3, rd, opcode}; ok = fit_i; end
            3'd2: begin enc = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode}; ok = fit_i; end
            3'd3: begin
                enc = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
                ok  = fit_b && !imm[0];
            end
            3'd4: begin enc = {imm[31:12], rd, opcode}; ok = ~|imm[11:0]; end
            3'd5: begin
                enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                ok  = fit_j && !imm[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_instr  <= NOP;
            out_addr   <= '0;
            out_err    <= 1'b0;
            cnt        <= BASE;
            word_count <= '0;
            err_count  <= '0;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_instr <= ok ? enc : NOP;
            out_addr  <= cur;
            out_err   <= !ok;
            cnt       <= cur + ADDR_W'(4);
            if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
            if (!ok && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end else begin
            cnt <= cur;
            if (out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_instr_enc.sv
// tb_instr_enc: directed and random stimulus for instr_enc against an arithmetic reference model.
module tb_instr_enc;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, addr_load, out_valid, out_ready, out_err;
    logic [2:0]  fmt, func3;
    logic [6:0]  opcode, func7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, addr_val, out_instr, out_addr;
    logic [15:0] word_count, err_count;

    int checks = 0;
    int errors = 0;

    logic        m_valid = 1'b0, m_err = 1'b0;
    logic [31:0] m_instr = NOP, m_addr = '0, m_cnt = '0;
    int          m_wc = 0, m_ec = 0;

    always #5 clk = ~clk;

    instr_enc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
        .opcode(opcode), .rd(rd), .func3(func3), .rs1(rs1), .rs2(rs2), .func7(func7),
        .imm(imm), .addr_load(addr_load), .addr_val(addr_val), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
        .word_count(word_count), .err_count(err_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoder: range checks on the signed value, fields placed by shift and mask.
    function automatic logic [31:0] ref_word(output logic e);
        longint s = longint'($signed(imm));
        logic [31:0] r;
        logic [31:0] base = (32'(rs1) << 15) | (32'(func3) << 12) | 32'(opcode);
        logic [31:0] dst  = 32'(rd) << 7;
        logic [31:0] src2 = 32'(rs2) << 20;
        r = 0;
        e = 1'b1;
        case (fmt)
            3'd0: begin e = 0; r = (32'(func7) << 25) | src2 | dst | base; end
            3'd1: begin
                e = !(s >= -2048 && s <= 2047);
                r = ((imm & 32'hFFF) << 20) | dst | base;
            end
            3'd2: begin
                e = !(s >= -2048 && s <= 2047);
                r = (((imm >> 5) & 32'h7F) << 25) | src2 | ((imm & 32'h1F) << 7) | base;
            end
            3'd3: begin
                e = !(s >= -4096 && s <= 4094 && s % 2 == 0);
                r = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | src2
                  | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | base;
            end
            3'd4: begin
                e = (imm % 4096) != 0;
                r = (imm & 32'hFFFF_F000) | dst | 32'(opcode);
            end
            3'd5: begin
                e = !(s >= -1048576 && s <= 1048574 && s % 2 == 0);
                r = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 11) & 1) << 20) | (imm & 32'h000F_F000) | dst | 32'(opcode);
            end
            default: ;
        endcase
        return e ? NOP : r;
    endfunction

    task automatic step();
        logic acc, e;
        logic [31:0] w, ld, cur;
        @(negedge clk);
        if (!rst) chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
        acc = !rst && in_valid && (!m_valid || out_ready);
        w   = ref_word(e);
        ld  = addr_val & ~32'h3;
        cur = addr_load ? ld : m_cnt;
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 0; m_instr = NOP; m_addr = 0; m_err = 0; m_cnt = 0; m_wc = 0; m_ec = 0;
        end else if (acc) begin
            m_valid = 1; m_instr = w; m_err = e; m_addr = cur; m_cnt = cur + 4;
            if (m_wc < 65535) m_wc++;
            if (e && m_ec < 65535) m_ec++;
        end else begin
            m_cnt = cur;
            if (out_ready) m_valid = 0;
        end
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_instr", out_instr, m_instr);
        chk("out_addr", out_addr, m_addr);
        chk("out_err", 32'(out_err), 32'(m_err));
        chk("word_count", 32'(word_count), 32'(m_wc));
        chk("err_count", 32'(err_count), 32'(m_ec));
    endtask

    task automatic load(input int f, input int op, input int d, input int f3, input int s1,
                        input int s2, input int f7, input logic [31:0] v);
        fmt = 3'(f); opcode = 7'(op); rd = 5'(d); func3 = 3'(f3);
        rs1 = 5'(s1); rs2 = 5'(s2); func7 = 7'(f7); imm = v;
    endtask

    task automatic send(input int f, input int op, input int d, input int f3, input int s1,
                        input int s2, input int f7, input logic [31:0] v);
        load(f, op, d, f3, s1, s2, f7, v);
        in_valid = 1;
        step();
        in_valid = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] edges [12] = '{32'd2047, 32'd2048, -32'd2048, -32'd2049, 32'd4094, -32'd4096,
                                    -32'd4098, 32'd1048574, 32'd1048576, -32'd1048576, 32'd3, 32'h1000};
        case ($urandom_range(0, 3))
            0: return edges[$urandom_range(0, 11)];
            1: return 32'($signed($urandom_range(0, 10000)) - 5000);
            2: return $urandom & 32'hFFFF_F000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1; in_valid = 0; addr_load = 0; addr_val = 0; out_ready = 1;
        load(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        do_reset();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_instr", out_instr, NOP);
        chk("rst_in_ready", 32'(in_ready), 1);

        send(0, 'h33, 3, 0, 1, 2, 0, 0);
        chk("r_add", out_instr, 32'h002081B3);
        chk("r_add_addr", out_addr, 0);
        do_reset();
        send(1, 'h13, 1, 0, 0, 0, 0, 32'hFFFF_FFFF);
        chk("addi", out_instr, 32'hFFF00093);
        chk("addi_addr", out_addr, 0);
        send(2, 'h23, 0, 2, 1, 2, 0, 8);
        chk("sw", out_instr, 32'h0020A423);
        chk("sw_addr", out_addr, 4);
        send(3, 'h63, 0, 0, 0, 0, 0, -32'd4);
        chk("beq", out_instr, 32'hFE000EE3);
        send(5, 'h6F, 1, 0, 0, 0, 0, 8);
        chk("jal", out_instr, 32'h008000EF);

        do_reset();
        send(3, 'h63, 0, 0, 0, 0, 0, 3);
        chk("b_odd_err", 32'(out_err), 1);
        chk("b_odd_nop", out_instr, NOP);
        send(1, 'h13, 1, 0, 0, 0, 0, 2048);
        chk("i_range_err", 32'(out_err), 1);
        chk("i_range_nop", out_instr, NOP);
        chk("err_count2", 32'(err_count), 2);

        addr_load = 1; addr_val = 32'h103;
        send(1, 'h13, 1, 0, 0, 0, 0, 1);
        addr_load = 0;
        chk("ld_addr0", out_addr, 32'h100);
        send(1, 'h13, 2, 0, 0, 0, 0, 2);
        chk("ld_addr1", out_addr, 32'h104);
        out_ready = 0;
        load(1, 'h13, 3, 0, 0, 0, 0, 3);
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_addr", out_addr, 32'h104);
            chk("hold_instr", out_instr, 32'h00200113);
            chk("hold_ready", 32'(in_ready), 0);
        end
        out_ready = 1;
        step();
        chk("ld_addr2", out_addr, 32'h108);
        load(1, 'h13, 4, 0, 0, 0, 0, 4);
        step();
        in_valid = 0;
        out_ready = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        chk("rst_hold_valid", 32'(out_valid), 0);
        out_ready = 1;
        send(0, 'h33, 1, 0, 0, 0, 0, 0);
        chk("rst_base_addr", out_addr, 0);

        for (int n = 0; n < 4000; n++) begin
            rst       = ($urandom_range(0, 299) == 0);
            addr_load = ($urandom_range(0, 19) == 0);
            addr_val  = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            load($urandom_range(0, 7), $urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, rand_imm());
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
